// File: rtl/port_in_debounce_if.sv
// Pin-conditioning bus between the input-port pins/read register and port_in_debounce.
// Define PORT_IN_IRQ_EN to add the interrupt mask and acknowledge signals.
interface port_in_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pins_in;
  logic             clr_change;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             change;
  logic             irq;
`ifdef PORT_IN_IRQ_EN
  logic [WIDTH-1:0] irq_mask;
  logic             irq_ack;

  modport master (
    output pins_in, clr_change, irq_mask, irq_ack,
    input  data_out, rise, fall, change, irq
  );

  modport slave (
    input  pins_in, clr_change, irq_mask, irq_ack,
    output data_out, rise, fall, change, irq
  );
`else
  modport master (
    output pins_in, clr_change,
    input  data_out, rise, fall, change, irq
  );

  modport slave (
    input  pins_in, clr_change,
    output data_out, rise, fall, change, irq
  );
`endif
endinterface

// File: rtl/port_in_debounce.sv
// Per-bit synchroniser, debouncer and edge detector feeding the input-port read register.
// Optional interrupt output is enabled by defining PORT_IN_IRQ_EN.
module port_in_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  port_in_debounce_if.slave  bus
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             change_q;
  logic             irq_q;

  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic             change_d;
  logic             irq_d;

  // Two-flop synchroniser; pins_in is fully asynchronous to clk.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= bus.pins_in;
      sync_q    <= sync_meta;
    end
  end

  // State register: per-bit FSM state, counters and registered outputs.
  // NOTE: the per-bit state/counter arrays are reset explicitly, since a mid-debounce count must be discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      data_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      data_q   <= data_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
      irq_q    <= irq_d;
    end
  end

  // Next-state logic, independent per bit.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        STABLE: begin
          if (sync_q[i] != data_q[i]) begin
            state_d[i] = CHANGING;
            cnt_d[i]   = CW'(1);
          end else begin
            cnt_d[i]   = '0;
          end
        end
        CHANGING: begin
          if (sync_q[i] == data_q[i] || cnt_q[i] == CNT_MAX) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output logic: an accepted bit updates data_out and pulses rise or fall on the same edge.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (state_q[i] == CHANGING) && (sync_q[i] != data_q[i]) && (cnt_q[i] == CNT_MAX);
    end
    data_d   = (data_q & ~accept) | (sync_q & accept);
    rise_d   = accept & sync_q;
    fall_d   = accept & ~sync_q;
    // A new edge wins over a simultaneous clear.
    change_d = (|accept) | (change_q & ~bus.clr_change);
`ifdef PORT_IN_IRQ_EN
    irq_d    = (|(accept & bus.irq_mask)) | (irq_q & ~bus.irq_ack);
`else
    irq_d    = 1'b0;
`endif
  end

  assign bus.data_out = data_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.change   = change_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_port_in_debounce.sv
// Self-checking bench for port_in_debounce: directed scenarios plus random bouncing pins
// compared every cycle against a sliding-window behavioural model.
module tb_port_in_debounce;

  localparam int W  = 8;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  port_in_debounce_if #(.WIDTH(W)) bus ();

  port_in_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a bit flips when the synchronised level seen on the last DC+1 edges all differ from it.
  logic [W-1:0] m_s1, m_s2, m_data, m_rise, m_fall, m_acc;
  logic         m_change, m_irq;
  logic [W-1:0] m_hist [DC];

  always_comb begin
    m_acc = m_s2 ^ m_data;
    for (int j = 0; j < DC; j++) m_acc = m_acc & (m_hist[j] ^ m_data);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1     <= '0;
      m_s2     <= '0;
      m_data   <= '0;
      m_rise   <= '0;
      m_fall   <= '0;
      m_change <= 1'b0;
      m_irq    <= 1'b0;
      for (int j = 0; j < DC; j++) m_hist[j] <= '0;
    end else begin
      m_s1     <= bus.pins_in;
      m_s2     <= m_s1;
      m_hist[0] <= m_s2;
      for (int j = 1; j < DC; j++) m_hist[j] <= m_hist[j-1];
      m_data   <= m_data ^ m_acc;
      m_rise   <= m_acc & ~m_data;
      m_fall   <= m_acc & m_data;
      m_change <= (|m_acc) | (m_change & ~bus.clr_change);
`ifdef PORT_IN_IRQ_EN
      m_irq    <= (|(m_acc & bus.irq_mask)) | (m_irq & ~bus.irq_ack);
`else
      m_irq    <= 1'b0;
`endif
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model data_out", 32'(bus.data_out), 32'(m_data));
      check("model rise",     32'(bus.rise),     32'(m_rise));
      check("model fall",     32'(bus.fall),     32'(m_fall));
      check("model change",   32'(bus.change),   32'(m_change));
      check("model irq",      32'(bus.irq),      32'(m_irq));
    end
  end

  task automatic drive_slot();
    @(negedge clk);
    #1;
  endtask

  logic [W-1:0] flips;

  initial begin
    reset          = 1'b1;
    bus.pins_in    = '0;
    bus.clr_change = 1'b0;
`ifdef PORT_IN_IRQ_EN
    bus.irq_mask   = 8'h08;
    bus.irq_ack    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Quiet pins after reset: nothing moves.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle data_out", 32'(bus.data_out), 32'h00);
      check("idle pulses", 32'({bus.rise, bus.fall}), 32'h0);
      check("idle change", 32'(bus.change), 32'h0);
    end

    // Clean step on bit 0 lands 2+DC edges after the first sampling edge.
    drive_slot();
    bus.pins_in = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("step data_out[0]", 32'(bus.data_out[0]), 32'(k >= 7));
      check("step rise[0]", 32'(bus.rise[0]), 32'(k == 7));
    end
    check("step change", 32'(bus.change), 32'h1);

    // Three-cycle bounce on bit 1 is rejected.
    drive_slot();
    bus.pins_in = 8'h03;
    repeat (3) drive_slot();
    bus.pins_in = 8'h01;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("bounce data_out", 32'(bus.data_out), 32'h01);
      check("bounce rise", 32'(bus.rise), 32'h00);
    end
    check("bounce change", 32'(bus.change), 32'h1);

    // Move to 8'h80, then swap two bits on one input change.
    drive_slot();
    bus.pins_in = 8'h80;
    repeat (10) @(negedge clk);
    check("pre-swap data_out", 32'(bus.data_out), 32'h80);
    #1 bus.pins_in = 8'h04;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) check("swap before", 32'(bus.data_out), 32'h80);
    end
    check("swap data_out", 32'(bus.data_out), 32'h04);
    check("swap rise", 32'(bus.rise), 32'h04);
    check("swap fall", 32'(bus.fall), 32'h80);

    // Clear with no edge, then clear colliding with a new rise.
    repeat (3) drive_slot();
    bus.clr_change = 1'b1;
    @(negedge clk);
    check("clear change", 32'(bus.change), 32'h0);
    #1 bus.clr_change = 1'b0;
    bus.pins_in = 8'h05;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) #1 bus.clr_change = 1'b1;
    end
    check("collide rise", 32'(bus.rise), 32'h01);
    check("collide change", 32'(bus.change), 32'h1);
    #1 bus.clr_change = 1'b0;
    repeat (2) drive_slot();
    bus.clr_change = 1'b1;
    @(negedge clk);
    check("late clear change", 32'(bus.change), 32'h0);
    #1 bus.clr_change = 1'b0;

    // Reset in the middle of bit 3's count (cnt=3 after five edges).
    repeat (3) @(negedge clk);
    #1 bus.pins_in = 8'h0D;
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("reset data_out", 32'(bus.data_out), 32'h00);
    check("reset pulses", 32'({bus.rise, bus.fall}), 32'h0);
    check("reset flags", 32'({bus.change, bus.irq}), 32'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) check("post-reset before", 32'(bus.data_out), 32'h00);
    end
    check("post-reset data_out", 32'(bus.data_out), 32'h0D);
    check("post-reset rise", 32'(bus.rise), 32'h0D);
`ifdef PORT_IN_IRQ_EN
    check("irq set", 32'(bus.irq), 32'h1);
    #1 bus.irq_ack = 1'b1;
    @(negedge clk);
    check("irq ack", 32'(bus.irq), 32'h0);
    #1 bus.irq_ack = 1'b0;
`else
    check("irq tied", 32'(bus.irq), 32'h0);
`endif

    // Random bouncing pins, occasional clears and resets.
    for (int c = 0; c < 3000; c++) begin
      drive_slot();
      reset = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < W; b++) flips[b] = ($urandom_range(0, 9) == 0);
      bus.pins_in    = bus.pins_in ^ flips;
      bus.clr_change = ($urandom_range(0, 5) == 0);
`ifdef PORT_IN_IRQ_EN
      bus.irq_ack    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) bus.irq_mask = 8'($urandom);
`endif
    end
    drive_slot();
    reset          = 1'b0;
    bus.clr_change = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
